instruction_memory_server: RTL

//  Responder end of the instruction-fetch interface: holds the program and returns words to the fetch stage.
//  A byte-serial loader fills the array little-endian; after load the block answers fetch reads.

---
 rtl/instruction_memory_server.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/instruction_memory_server.sv
// instruction_memory_server
//   Holds the program and answers instruction fetches.
//   A byte-serial loader fills the word array little-endian (first byte of a
//   word lands in bits [7:0]); once a program is loaded, fetch reads return
//   mem[ins_pointer] one cycle after the request, with a one-cycle ins_valid.
//
// Ports
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   load_valid/ready     byte handshake; load_data is the byte, load_last marks
//                        the final byte of the program
//   load_overflow        sticky: a byte was offered while the array was full
//   ins_pointer          word address requested by fetch
//   ins_read_enable      fetch read request
//   instruction_memory   read data (holds between reads)
//   ins_valid            one-cycle strobe: instruction_memory was updated
//   out_of_range         with ins_valid: the pointer was beyond the program
//   program_length       number of words loaded
//   mem_ready            a program is loaded and fetch reads are served
//   fsm_state            current controller state, for observation
//
// Handshake: a byte is transferred on a rising edge where load_valid and
// load_ready are both 1. load_ready does not depend on load_valid; load_data
// and load_last are only meaningful while load_valid is 1.
module instruction_memory_server #(
    parameter int WORD_SIZE     = 32,
    parameter int INS_ADDR_SIZE = 8,
    parameter int DEPTH         = 256
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     load_valid,
    input  logic [7:0]               load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     load_overflow,
    input  logic [INS_ADDR_SIZE-1:0] ins_pointer,
    input  logic                     ins_read_enable,
    output logic [WORD_SIZE-1:0]     instruction_memory,
    output logic                     ins_valid,
    output logic                     out_of_range,
    output logic [INS_ADDR_SIZE:0]   program_length,
    output logic                     mem_ready,
    output logic [1:0]               fsm_state
);

    localparam int BYTES  = WORD_SIZE / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [INS_ADDR_SIZE:0] DEPTH_L   = (INS_ADDR_SIZE + 1)'(DEPTH);
    localparam logic [BIDX_W-1:0]      LAST_BYTE = BIDX_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WORD_SIZE-1:0]     mem [0:DEPTH-1];

    logic [BIDX_W-1:0]        byte_idx, byte_idx_next;
    logic [INS_ADDR_SIZE-1:0] wr_addr, wr_addr_next;
    logic [WORD_SIZE-1:0]     word_buf, word_buf_next;
    logic [INS_ADDR_SIZE:0]   length_next;

    // Load-path values as seen by the byte being accepted: any byte outside
    // LOAD starts a fresh program at word 0, byte 0.
    logic [BIDX_W-1:0]        eff_idx;
    logic [INS_ADDR_SIZE-1:0] eff_addr;
    logic [WORD_SIZE-1:0]     eff_buf;
    logic [INS_ADDR_SIZE:0]   eff_len;
    logic [WORD_SIZE-1:0]     new_word;

    logic full, accept, word_done, rd_fire, rd_oor;

    assign full       = (program_length == DEPTH_L);
    assign load_ready = !full;
    assign accept     = load_valid && load_ready;
    assign mem_ready  = (state == READY);
    assign fsm_state  = state;

    // A reload byte in the same cycle as a read wins: the read is dropped.
    assign rd_fire = ins_read_enable && (state == READY) && !accept;
    assign rd_oor  = ({1'b0, ins_pointer} >= program_length);

    always_comb begin
        state_next    = state;
        eff_idx       = '0;
        eff_addr      = '0;
        eff_buf       = '0;
        eff_len       = '0;
        new_word      = '0;
        word_done     = 1'b0;
        byte_idx_next = byte_idx;
        wr_addr_next  = wr_addr;
        word_buf_next = word_buf;
        length_next   = program_length;

        if (state == LOAD) begin
            eff_idx  = byte_idx;
            eff_addr = wr_addr;
            eff_buf  = word_buf;
            eff_len  = program_length;
        end

        if (accept) begin
            // Upper bytes of eff_buf are still zero, so a short final word is
            // zero-filled for free.
            new_word  = eff_buf | (WORD_SIZE'(load_data) << {eff_idx, 3'b000});
            word_done = load_last || (eff_idx == LAST_BYTE);
            if (word_done) begin
                byte_idx_next = '0;
                wr_addr_next  = eff_addr + 1'b1;
                word_buf_next = '0;
                length_next   = eff_len + 1'b1;
            end else begin
                byte_idx_next = eff_idx + 1'b1;
                wr_addr_next  = eff_addr;
                word_buf_next = new_word;
                length_next   = eff_len;
            end

            if (load_last || (word_done && (length_next == DEPTH_L)))
                state_next = READY;
            else
                state_next = LOAD;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            byte_idx       <= '0;
            wr_addr        <= '0;
            word_buf       <= '0;
            program_length <= '0;
            load_overflow  <= 1'b0;
        end else begin
            state          <= state_next;
            byte_idx       <= byte_idx_next;
            wr_addr        <= wr_addr_next;
            word_buf       <= word_buf_next;
            program_length <= length_next;
            if (load_valid && full)
                load_overflow <= 1'b1;
        end
    end

    // Array is deliberately not reset; program_length gates what is reachable.
    always_ff @(posedge clock) begin
        if (word_done)
            mem[eff_addr] <= new_word;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instruction_memory <= '0;
            ins_valid          <= 1'b0;
            out_of_range       <= 1'b0;
        end else begin
            ins_valid    <= rd_fire;
            out_of_range <= rd_fire && rd_oor;
            if (rd_fire)
                instruction_memory <= rd_oor ? '0 : mem[ins_pointer];
        end
    end

endmodule
